// File: rtl/triad_encode_if.sv
// rtl/triad_encode_if.sv - request/status bundle between a triad requester and triad_encode
//
// Signals
//   h_strip      requester -> encoder  half-strip hit request, bit i = half-strip i
//   load         requester -> encoder  request strobe, h_strip sampled when 1
//   persist      requester -> encoder  dead time after a triad (gap is persist+1)
//   skip_cnt_rst requester -> encoder  synchronous clear of skip_cnt
//   triad        encoder -> requester  serial triad line
//   busy         encoder -> requester  encoder not idle
//   pend_full    encoder -> requester  one-deep pending buffer occupied
//   skip_cnt     encoder -> requester  saturating count of dropped requests
interface triad_encode_if #(
  parameter int SKIP_W = 8
);
  logic [3:0]        h_strip;
  logic              load;
  logic [3:0]        persist;
  logic              skip_cnt_rst;
  logic              triad;
  logic              busy;
  logic              pend_full;
  logic [SKIP_W-1:0] skip_cnt;

  modport master (
    output h_strip, load, persist, skip_cnt_rst,
    input  triad, busy, pend_full, skip_cnt
  );

  modport slave (
    input  h_strip, load, persist, skip_cnt_rst,
    output triad, busy, pend_full, skip_cnt
  );
endinterface

// File: rtl/triad_encode.sv
// rtl/triad_encode.sv - single-distrip serial triad transmitter with one-deep pending buffer
//
// Ports
//   clock  40 MHz system clock
//   reset  asynchronous active-low reset
//   bus    triad_encode_if.slave: h_strip/load/persist/skip_cnt_rst in,
//          triad/busy/pend_full/skip_cnt out
//
// A triad is three clocks on the line: 1, sel[1], sel[0], where sel is the
// index of the lowest set bit of the request. After each triad the line is
// held low for persist+1 clocks before the next triad may start.
module triad_encode #(
  parameter int SKIP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  triad_encode_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    STRIP = 3'd2,
    HALF  = 3'd3,
    DEAD  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        pend_sel_q, pend_sel_d;
  logic              pend_full_q, pend_full_d;
  logic [3:0]        dead_q, dead_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              triad_q, triad_d;

  logic              req_valid;
  logic [1:0]        req_sel;
  logic              req_taken;

  function automatic logic [1:0] lowest_set(input logic [3:0] h);
    if (h[0])      lowest_set = 2'd0;
    else if (h[1]) lowest_set = 2'd1;
    else if (h[2]) lowest_set = 2'd2;
    else           lowest_set = 2'd3;
  endfunction

  assign req_valid = bus.load && (bus.h_strip != 4'b0000);
  assign req_sel   = lowest_set(bus.h_strip);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pend_sel_d  = pend_sel_q;
    pend_full_d = pend_full_q;
    dead_d      = dead_q;
    skip_d      = skip_q;
    req_taken   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          sel_d     = req_sel;
          req_taken = 1'b1;
          state_d   = START;
        end
      end
      START: state_d = STRIP;
      STRIP: state_d = HALF;
      HALF: begin
        // persist is captured here only, so the gap in flight is immune to later changes
        dead_d  = bus.persist;
        state_d = DEAD;
      end
      DEAD: begin
        if (dead_q == 4'd0) begin
          if (pend_full_q) begin
            sel_d       = pend_sel_q;
            pend_full_d = 1'b0;
            state_d     = START;
          end else if (req_valid) begin
            // A request on the exit edge starts directly instead of going through pending
            sel_d     = req_sel;
            req_taken = 1'b1;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dead_d = dead_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Requests not started directly go to pending, or are counted as dropped.
    // A draining pending slot still counts as full on that edge.
    if (req_valid && !req_taken) begin
      if (!pend_full_q) begin
        pend_sel_d  = req_sel;
        pend_full_d = 1'b1;
      end else if (skip_q != {SKIP_W{1'b1}}) begin
        skip_d = skip_q + {{(SKIP_W-1){1'b0}}, 1'b1};
      end
    end

    if (bus.skip_cnt_rst) begin
      skip_d = '0;
    end

    // The line is registered: it reflects the state being entered
    case (state_d)
      START:   triad_d = 1'b1;
      STRIP:   triad_d = sel_d[1];
      HALF:    triad_d = sel_d[0];
      default: triad_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      pend_sel_q  <= 2'd0;
      pend_full_q <= 1'b0;
      dead_q      <= 4'd0;
      skip_q      <= '0;
      triad_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pend_sel_q  <= pend_sel_d;
      pend_full_q <= pend_full_d;
      dead_q      <= dead_d;
      skip_q      <= skip_d;
      triad_q     <= triad_d;
    end
  end

  assign bus.triad     = triad_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.pend_full = pend_full_q;
  assign bus.skip_cnt  = skip_q;

endmodule
